// File: rtl/lcd_pkg.sv
// Shared definitions for the LCD update path: scheduler state encodings and
// default watchdog/holdoff settings, also used by the LCD controller.
package lcd_pkg;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_REQUEST   = 2'd1,
        ST_WAIT_DONE = 2'd2,
        ST_HOLDOFF   = 2'd3
    } lcd_state_e;

    localparam int DEFAULT_TIMEOUT_MAX    = 1000;
    localparam int DEFAULT_HOLDOFF_CYCLES = 20;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/rise_detect.sv
// Registered single-bit rising-edge detector with asynchronous active-low reset.
// A level already high when reset is released is ignored until it has been seen low.
module rise_detect (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic rise
);

    logic d_q;
    logic armed;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            d_q   <= 1'b0;
            armed <= 1'b0;
        end else begin
            d_q   <= d;
            armed <= armed | ~d;
        end
    end

    assign rise = d & ~d_q & armed;

endmodule

// File: rtl/lcd_update_scheduler.sv
// Turns change-detector events into single LCD redraw requests, coalescing
// changes that arrive mid-redraw into one pending update; guarded by a watchdog.
module lcd_update_scheduler
    import lcd_pkg::*;
#(
    parameter int  MAX_VALUE      = 5,
    parameter int  TIMEOUT_MAX    = DEFAULT_TIMEOUT_MAX,
    parameter int  HOLDOFF_CYCLES = DEFAULT_HOLDOFF_CYCLES,
    localparam int W              = $clog2(MAX_VALUE)
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         change,
    input  logic [W-1:0] the_signal,
    input  logic         lcd_ready,
    input  logic         lcd_done,
    output logic         lcd_req,
    output logic [W-1:0] lcd_value,
    output logic         busy,
    output logic         coalesced,
    output logic         timeout_err,
    output lcd_state_e   state_dbg
);

    // Handshake: a request transfers on any clock where lcd_req and lcd_ready
    // are both high; until then lcd_req stays high and lcd_value is held.
    localparam int              CNT_TOP = max_int(TIMEOUT_MAX, HOLDOFF_CYCLES);
    localparam int              CW      = $clog2(CNT_TOP + 1);
    localparam logic [CW-1:0]   CNT_SAT = CW'(CNT_TOP);
    localparam logic [CW-1:0]   TO_LAST = CW'(TIMEOUT_MAX - 1);
    localparam logic [CW-1:0]   HO_LAST = CW'(max_int(HOLDOFF_CYCLES - 1, 0));
    localparam lcd_state_e      AFTER_REDRAW = (HOLDOFF_CYCLES == 0) ? ST_IDLE : ST_HOLDOFF;

    lcd_state_e    state, state_next;
    logic [CW-1:0] cnt;
    logic          chg_edge;
    logic          pend_valid;
    logic [W-1:0]  pend_value;
    logic          cnt_clr, load_edge, load_pend, abort, done_ok;

    rise_detect u_rise (
        .clk   (clk),
        .reset (reset),
        .d     (change),
        .rise  (chg_edge)
    );

    always_comb begin
        state_next = state;
        cnt_clr    = 1'b0;
        load_edge  = 1'b0;
        load_pend  = 1'b0;
        abort      = 1'b0;
        done_ok    = 1'b0;
        case (state)
            ST_IDLE: begin
                if (chg_edge) begin
                    load_edge  = 1'b1;
                    state_next = ST_REQUEST;
                    cnt_clr    = 1'b1;
                end else if (pend_valid) begin
                    load_pend  = 1'b1;
                    state_next = ST_REQUEST;
                    cnt_clr    = 1'b1;
                end
            end
            ST_REQUEST: begin
                if (lcd_ready) begin
                    state_next = ST_WAIT_DONE;
                    cnt_clr    = 1'b1;
                end else if (cnt == TO_LAST) begin
                    abort      = 1'b1;
                    state_next = AFTER_REDRAW;
                    cnt_clr    = 1'b1;
                end
            end
            ST_WAIT_DONE: begin
                if (lcd_done) begin
                    done_ok    = 1'b1;
                    state_next = AFTER_REDRAW;
                    cnt_clr    = 1'b1;
                end else if (cnt == TO_LAST) begin
                    abort      = 1'b1;
                    state_next = AFTER_REDRAW;
                    cnt_clr    = 1'b1;
                end
            end
            ST_HOLDOFF: begin
                if (cnt == HO_LAST) begin
                    state_next = ST_IDLE;
                    cnt_clr    = 1'b1;
                end
            end
            default: state_next = ST_IDLE;
        endcase
        lcd_req = (state == ST_REQUEST);
        busy    = (state != ST_IDLE);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= ST_IDLE;
            cnt         <= '0;
            lcd_value   <= '0;
            pend_valid  <= 1'b0;
            pend_value  <= '0;
            coalesced   <= 1'b0;
            timeout_err <= 1'b0;
        end else begin
            state <= state_next;
            if (cnt_clr) begin
                cnt <= '0;
            end else if (cnt != CNT_SAT) begin
                cnt <= cnt + 1'b1;
            end
            if (load_edge) begin
                lcd_value <= the_signal;
            end else if (load_pend) begin
                lcd_value <= pend_value;
            end
            // An edge in IDLE beats a pending update, so that also counts as an overwrite.
            coalesced <= chg_edge & pend_valid;
            if (chg_edge && state != ST_IDLE) begin
                pend_valid <= 1'b1;
                pend_value <= the_signal;
            end else if (chg_edge || load_pend) begin
                pend_valid <= 1'b0;
            end
            if (abort) begin
                timeout_err <= 1'b1;
            end else if (done_ok) begin
                timeout_err <= 1'b0;
            end
        end
    end

    assign state_dbg = state;

endmodule

// File: tb/tb_lcd_update_scheduler.sv
// Directed bench for lcd_update_scheduler: one main instance with the default
// watchdog and a second with a short watchdog, sharing all inputs.
module tb_lcd_update_scheduler;
    import lcd_pkg::*;

    localparam int W = 3;

    logic         clk = 1'b0;
    logic         reset;
    logic         change;
    logic [W-1:0] the_signal;
    logic         lcd_ready;
    logic         lcd_done;

    logic         lcd_req, busy, coalesced, timeout_err;
    logic [W-1:0] lcd_value;
    lcd_state_e   state_dbg;

    logic         wd_req, wd_busy, wd_coal, wd_terr;
    logic [W-1:0] wd_value;
    lcd_state_e   wd_state;

    int checks = 0;
    int errors = 0;
    int acc_count = 0;
    int coal_count = 0;

    // clock / reset
    always #5 clk = ~clk;

    lcd_update_scheduler #(.MAX_VALUE(5), .TIMEOUT_MAX(1000), .HOLDOFF_CYCLES(20)) dut (
        .clk(clk), .reset(reset), .change(change), .the_signal(the_signal),
        .lcd_ready(lcd_ready), .lcd_done(lcd_done), .lcd_req(lcd_req),
        .lcd_value(lcd_value), .busy(busy), .coalesced(coalesced),
        .timeout_err(timeout_err), .state_dbg(state_dbg)
    );

    lcd_update_scheduler #(.MAX_VALUE(5), .TIMEOUT_MAX(16), .HOLDOFF_CYCLES(20)) dut_wd (
        .clk(clk), .reset(reset), .change(change), .the_signal(the_signal),
        .lcd_ready(lcd_ready), .lcd_done(lcd_done), .lcd_req(wd_req),
        .lcd_value(wd_value), .busy(wd_busy), .coalesced(wd_coal),
        .timeout_err(wd_terr), .state_dbg(wd_state)
    );

    // Count accepted requests and coalesce pulses on the main instance.
    always @(negedge clk) begin
        if (reset === 1'b1) begin
            if (lcd_req === 1'b1 && lcd_ready === 1'b1) acc_count++;
            if (coalesced === 1'b1) coal_count++;
        end
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish in time");
        $fatal(1, "global timeout");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (busy !== 1'b0 && n < 40) begin
            tick();
            n++;
        end
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL wait_idle: busy=%b after %0d cycles, expected 0", busy, n);
        end
    endtask

    // Called in WAIT_DONE: pulse lcd_done next cycle and drain the holdoff.
    task automatic finish_redraw();
        tick();
        lcd_done = 1'b1;
        tick();
        lcd_done = 1'b0;
        wait_idle();
    endtask

    task automatic pulse_reset();
        change = 1'b0;
        lcd_done = 1'b0;
        reset = 1'b0;
        tick();
        reset = 1'b1;
        tick();
    endtask

    task automatic test_reset();
        reset = 1'b0; change = 1'b0; lcd_ready = 1'b0; lcd_done = 1'b0; the_signal = '0;
        repeat (3) tick();
        checks++; if (lcd_req !== 1'b0) begin errors++; $display("FAIL reset_req: got %b expected 0", lcd_req); end
        checks++; if (lcd_value !== 3'd0) begin errors++; $display("FAIL reset_value: got %0d expected 0", lcd_value); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
        checks++; if (coalesced !== 1'b0) begin errors++; $display("FAIL reset_coalesced: got %b expected 0", coalesced); end
        checks++; if (timeout_err !== 1'b0) begin errors++; $display("FAIL reset_timeout_err: got %b expected 0", timeout_err); end
        checks++; if (state_dbg !== ST_IDLE) begin errors++; $display("FAIL reset_state: got %0d expected 0", state_dbg); end
        reset = 1'b1;
        tick();
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_release_busy: got %b expected 0", busy); end
    endtask

    task automatic test_single_change();
        int base = acc_count;
        the_signal = 3'd3; lcd_ready = 1'b1; change = 1'b0;
        tick();
        change = 1'b1;
        tick();
        checks++; if (lcd_req !== 1'b1) begin errors++; $display("FAIL single_req: got %b expected 1", lcd_req); end
        checks++; if (lcd_value !== 3'd3) begin errors++; $display("FAIL single_value: got %0d expected 3", lcd_value); end
        tick();
        checks++; if (state_dbg !== ST_WAIT_DONE || lcd_req !== 1'b0) begin errors++; $display("FAIL single_wait: state=%0d req=%b expected 2/0", state_dbg, lcd_req); end
        repeat (4) tick();
        lcd_done = 1'b1;
        tick();
        lcd_done = 1'b0;
        checks++; if (state_dbg !== ST_HOLDOFF) begin errors++; $display("FAIL single_holdoff: state=%0d expected 3", state_dbg); end
        for (int j = 2; j <= 21; j++) begin
            tick();
            if (j == 15) change = 1'b0;
            if (j == 20) begin
                checks++; if (busy !== 1'b1) begin errors++; $display("FAIL single_busy_hold: got %b expected 1", busy); end
            end
            if (j == 21) begin
                checks++; if (busy !== 1'b0) begin errors++; $display("FAIL single_busy_low: got %b expected 0", busy); end
            end
        end
        repeat (5) tick();
        checks++; if (acc_count - base !== 1) begin errors++; $display("FAIL single_req_count: got %0d expected 1", acc_count - base); end
        checks++; if (lcd_value !== 3'd3) begin errors++; $display("FAIL single_value_hold: got %0d expected 3", lcd_value); end
    endtask

    task automatic test_coalesce();
        int base = acc_count;
        int cbase = coal_count;
        the_signal = 3'd3; change = 1'b1;
        tick();
        change = 1'b0;
        tick();
        checks++; if (state_dbg !== ST_WAIT_DONE) begin errors++; $display("FAIL coal_wait: state=%0d expected 2", state_dbg); end
        the_signal = 3'd1; change = 1'b1; tick(); change = 1'b0; tick();
        the_signal = 3'd2; change = 1'b1; tick(); change = 1'b0; tick();
        the_signal = 3'd4; change = 1'b1; tick(); change = 1'b0; tick();
        checks++; if (lcd_value !== 3'd3) begin errors++; $display("FAIL coal_value_stable: got %0d expected 3", lcd_value); end
        checks++; if (coal_count - cbase !== 2) begin errors++; $display("FAIL coal_pulses: got %0d expected 2", coal_count - cbase); end
        lcd_done = 1'b1;
        tick();
        lcd_done = 1'b0;
        repeat (20) tick();
        checks++; if (busy !== 1'b0 || lcd_req !== 1'b0) begin errors++; $display("FAIL coal_idle: busy=%b req=%b expected 0/0", busy, lcd_req); end
        tick();
        checks++; if (lcd_req !== 1'b1) begin errors++; $display("FAIL coal_followup_req: got %b expected 1", lcd_req); end
        checks++; if (lcd_value !== 3'd4) begin errors++; $display("FAIL coal_followup_value: got %0d expected 4", lcd_value); end
        tick();
        finish_redraw();
        repeat (5) tick();
        checks++; if (acc_count - base !== 2) begin errors++; $display("FAIL coal_req_count: got %0d expected 2", acc_count - base); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL coal_final_busy: got %b expected 0", busy); end
    endtask

    task automatic test_backpressure();
        int base = acc_count;
        int bad = 0;
        lcd_ready = 1'b0; the_signal = 3'd1; change = 1'b1;
        tick();
        change = 1'b0; the_signal = 3'd0;
        for (int i = 0; i < 50; i++) begin
            if (lcd_req !== 1'b1 || lcd_value !== 3'd1) bad++;
            tick();
        end
        checks++; if (bad != 0) begin errors++; $display("FAIL bp_hold: %0d cycles without req=1 value=1, expected 0", bad); end
        // Accept and a new edge in the same cycle.
        lcd_ready = 1'b1; the_signal = 3'd4; change = 1'b1;
        checks++; if (lcd_req !== 1'b1) begin errors++; $display("FAIL bp_req_at_accept: got %b expected 1", lcd_req); end
        tick();
        change = 1'b0;
        checks++; if (state_dbg !== ST_WAIT_DONE || lcd_value !== 3'd1) begin errors++; $display("FAIL bp_accept: state=%0d value=%0d expected 2/1", state_dbg, lcd_value); end
        checks++; if (acc_count - base !== 1) begin errors++; $display("FAIL bp_accept_count: got %0d expected 1", acc_count - base); end
        finish_redraw();
        tick();
        checks++; if (lcd_req !== 1'b1 || lcd_value !== 3'd4) begin errors++; $display("FAIL bp_pending_req: req=%b value=%0d expected 1/4", lcd_req, lcd_value); end
        tick();
        finish_redraw();
        checks++; if (acc_count - base !== 2) begin errors++; $display("FAIL bp_req_count: got %0d expected 2", acc_count - base); end
        checks++; if (timeout_err !== 1'b0) begin errors++; $display("FAIL bp_no_timeout: got %b expected 0", timeout_err); end
    endtask

    task automatic test_watchdog();
        int n = 0;
        pulse_reset();
        lcd_ready = 1'b1; the_signal = 3'd2; change = 1'b1;
        tick();
        change = 1'b0;
        tick();
        repeat (15) tick();
        checks++; if (wd_state !== ST_WAIT_DONE || wd_terr !== 1'b0) begin errors++; $display("FAIL wd_before: state=%0d terr=%b expected 2/0", wd_state, wd_terr); end
        tick();
        checks++; if (wd_terr !== 1'b1) begin errors++; $display("FAIL wd_timeout_err: got %b expected 1", wd_terr); end
        checks++; if (wd_state !== ST_HOLDOFF || wd_req !== 1'b0) begin errors++; $display("FAIL wd_abort: state=%0d req=%b expected 3/0", wd_state, wd_req); end
        repeat (2) tick();
        lcd_done = 1'b1;
        tick();
        lcd_done = 1'b0;
        checks++; if (wd_terr !== 1'b1 || wd_state !== ST_HOLDOFF) begin errors++; $display("FAIL wd_stray_done: terr=%b state=%0d expected 1/3", wd_terr, wd_state); end
        repeat (16) tick();
        checks++; if (wd_busy !== 1'b1) begin errors++; $display("FAIL wd_holdoff_busy: got %b expected 1", wd_busy); end
        tick();
        checks++; if (wd_busy !== 1'b0 || wd_terr !== 1'b1) begin errors++; $display("FAIL wd_idle: busy=%b terr=%b expected 0/1", wd_busy, wd_terr); end
        the_signal = 3'd4; change = 1'b1;
        tick();
        change = 1'b0;
        tick();
        checks++; if (wd_state !== ST_WAIT_DONE || wd_terr !== 1'b1) begin errors++; $display("FAIL wd_retry: state=%0d terr=%b expected 2/1", wd_state, wd_terr); end
        lcd_done = 1'b1;
        tick();
        lcd_done = 1'b0;
        checks++; if (wd_terr !== 1'b0) begin errors++; $display("FAIL wd_clear: got %b expected 0", wd_terr); end
        checks++; if (wd_coal !== 1'b0) begin errors++; $display("FAIL wd_coalesced: got %b expected 0", wd_coal); end
        while (wd_busy !== 1'b0 && n < 40) begin
            tick();
            n++;
        end
        checks++; if (wd_busy !== 1'b0) begin errors++; $display("FAIL wd_drain: busy=%b after %0d cycles, expected 0", wd_busy, n); end
    endtask

    task automatic test_simultaneous();
        int base;
        int cbase;
        pulse_reset();
        lcd_ready = 1'b1;
        base = acc_count;
        cbase = coal_count;
        the_signal = 3'd3; change = 1'b1;
        tick();
        change = 1'b0;
        tick();
        the_signal = 3'd2; change = 1'b1;
        tick();
        change = 1'b0;
        tick();
        lcd_done = 1'b1;
        tick();
        lcd_done = 1'b0;
        repeat (20) tick();
        checks++; if (state_dbg !== ST_IDLE || lcd_req !== 1'b0) begin errors++; $display("FAIL sim_idle: state=%0d req=%b expected 0/0", state_dbg, lcd_req); end
        the_signal = 3'd0; change = 1'b1;
        tick();
        change = 1'b0;
        checks++; if (lcd_req !== 1'b1 || lcd_value !== 3'd0) begin errors++; $display("FAIL sim_req: req=%b value=%0d expected 1/0", lcd_req, lcd_value); end
        checks++; if (coalesced !== 1'b1) begin errors++; $display("FAIL sim_coalesced: got %b expected 1", coalesced); end
        tick();
        checks++; if (coalesced !== 1'b0) begin errors++; $display("FAIL sim_coalesced_pulse: got %b expected 0", coalesced); end
        finish_redraw();
        repeat (5) tick();
        checks++; if (acc_count - base !== 2) begin errors++; $display("FAIL sim_req_count: got %0d expected 2", acc_count - base); end
        checks++; if (coal_count - cbase !== 1) begin errors++; $display("FAIL sim_coal_count: got %0d expected 1", coal_count - cbase); end
    endtask

    task automatic test_reset_mid();
        int base;
        pulse_reset();
        lcd_ready = 1'b0; the_signal = 3'd3; change = 1'b1;
        tick();
        change = 1'b0;
        tick();
        the_signal = 3'd1; change = 1'b1;
        tick();
        #2 reset = 1'b0;
        #1;
        checks++; if (lcd_req !== 1'b0 || lcd_value !== 3'd0) begin errors++; $display("FAIL rmid_req_value: req=%b value=%0d expected 0/0", lcd_req, lcd_value); end
        checks++; if (busy !== 1'b0 || coalesced !== 1'b0 || timeout_err !== 1'b0) begin errors++; $display("FAIL rmid_flags: busy=%b coal=%b terr=%b expected 0/0/0", busy, coalesced, timeout_err); end
        tick();
        lcd_ready = 1'b1;
        reset = 1'b1;
        base = acc_count;
        repeat (10) tick();
        checks++; if (acc_count - base !== 0 || busy !== 1'b0) begin errors++; $display("FAIL rmid_no_request: reqs=%0d busy=%b expected 0/0", acc_count - base, busy); end
        change = 1'b0;
        tick();
        the_signal = 3'd2; change = 1'b1;
        tick();
        checks++; if (lcd_req !== 1'b1 || lcd_value !== 3'd2) begin errors++; $display("FAIL rmid_new_edge: req=%b value=%0d expected 1/2", lcd_req, lcd_value); end
        change = 1'b0;
        tick();
        finish_redraw();
    endtask

    initial begin
        test_reset();
        test_single_change();
        test_coalesce();
        test_backpressure();
        test_watchdog();
        test_simultaneous();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
